// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited memory reads into a circular buffer.
// Optional macro FETCHQ_BYPASS_EN forwards a response straight to instr0 when empty.
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic [1:0]               pop_cnt,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              instr0,
    output logic [31:0]              instr1,
    output logic                     instr0_valid,
    output logic                     instr1_valid,
    output logic [31:0]              instr0_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [2:0]    MAX_OUT_L = 3'(MAX_OUT);
    localparam logic [SW-1:0] DEPTH_L   = SW'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [2:0]      out_q;
    logic [31:0]     fetch_pc_q, head_pc_q;
    logic [31:0]     buf_q [DEPTH];

    logic [SW-1:0]   credit_sum;
    logic            grant, resp, push, consume, bypass_hit;
    logic [1:0]      pop_req;
    logic [CW-1:0]   pops, adv, count_nxt;
    logic [2:0]      out_nxt;
    logic [PW-1:0]   rd1_ptr;

    assign credit_sum = {1'b0, count_q} + SW'(out_q);
    assign mem_req    = !n_rst && en && (state_q == RUN)
                        && (out_q < MAX_OUT_L) && (credit_sum < DEPTH_L);
    assign mem_addr   = fetch_pc_q;
    assign grant      = mem_req && mem_gnt;
    assign resp       = en && mem_rvalid;
    assign rd1_ptr    = rd_ptr_q + PW'(1);
    assign count      = count_q;
    assign empty      = (count_q == '0);

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = en && (state_q == RUN) && (count_q == '0) && mem_rvalid;
`else
    assign bypass_hit = 1'b0;
`endif
    assign consume = bypass_hit && (pop_req != 2'd0) && !flush;
    assign push    = resp && (state_q == RUN) && !flush && !consume;

    // Clamp the pop request and limit it to what the queue actually holds
    always_comb begin
        pop_req = (pop_cnt > 2'd2) ? 2'd2 : pop_cnt;
        pops    = '0;
        if (count_q >= CW'(2))
            pops = CW'(pop_req);
        else if ((count_q == CW'(1)) && (pop_req != 2'd0))
            pops = CW'(1);
        adv       = pops + CW'(consume);
        count_nxt = count_q + CW'(push) - pops;
    end

    // Outstanding read tracking; a response with nothing outstanding cannot underflow
    always_comb begin
        out_nxt = out_q;
        if (grant)
            out_nxt = out_nxt + 3'd1;
        if (resp && (out_q != 3'd0))
            out_nxt = out_nxt - 3'd1;
    end

    // Pointer, count, PC and FSM state update; flush overrides pop and push
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q    <= RUN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else if (en) begin
            out_q <= out_nxt;
            if (grant)
                fetch_pc_q <= fetch_pc_q + 32'd4;
            if (flush) begin
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= flush_pc;
                head_pc_q  <= flush_pc;
                state_q    <= (out_nxt != 3'd0) ? DRAIN : RUN;
            end else begin
                count_q   <= count_nxt;
                rd_ptr_q  <= rd_ptr_q + PW'(adv);
                head_pc_q <= head_pc_q + (32'(adv) << 2);
                if (push)
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                if ((state_q == DRAIN) && (out_nxt == 3'd0))
                    state_q <= RUN;
            end
        end
    end

    // Entry storage; validity is tracked by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push)
            buf_q[wr_ptr_q] <= mem_rdata;
    end

    // Head and head+1 views; invalid slots read as zero
    always_comb begin
        instr0_valid = (count_q != '0);
        instr1_valid = (count_q >= CW'(2));
        instr0       = instr0_valid ? buf_q[rd_ptr_q] : 32'h0;
        instr1       = instr1_valid ? buf_q[rd1_ptr] : 32'h0;
        instr0_pc    = head_pc_q;
        if (bypass_hit) begin
            instr0       = mem_rdata;
            instr0_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1-cycle memory model and injectable responses.
// Build with FETCHQ_BYPASS_EN defined to exercise the bypass path.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        n_rst, en, flush, mem_gnt;
    logic [31:0] flush_pc;
    logic [1:0]  pop_cnt;
    logic        mem_req, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic [31:0] instr0, instr1, instr0_pc;
    logic        instr0_valid, instr1_valid;
    logic [3:0]  count;
    logic        empty;

    logic        auto_rsp, inj;
    logic [31:0] inj_data;
    logic        rv_q;
    logic [31:0] ad_q;

    int tests  = 0;
    int failed = 0;

    fetch_queue dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .pop_cnt      (pop_cnt),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .instr0       (instr0),
        .instr1       (instr1),
        .instr0_valid (instr0_valid),
        .instr1_valid (instr1_valid),
        .instr0_pc    (instr0_pc),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a * 32'h0001_0001;
    endfunction

    // Memory model: every grant is answered one cycle later
    always @(posedge clk) begin
        rv_q <= mem_req && mem_gnt;
        ad_q <= mem_addr;
    end

    assign mem_rvalid = (auto_rsp && rv_q) || inj;
    assign mem_rdata  = inj ? inj_data : data_of(ad_q);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_rst = 1'b1; en = 1'b1; flush = 1'b0; flush_pc = '0;
        pop_cnt = 2'd0; mem_gnt = 1'b1;
        auto_rsp = 1'b0; inj = 1'b0; inj_data = '0;
        tick();
        tick();
        auto_rsp = 1'b1;
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_addr",  mem_addr, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_v0",    32'(instr0_valid), 32'd0);
        check("rst_v1",    32'(instr1_valid), 32'd0);
        check("rst_i0",    instr0, 32'h0);
        check("rst_i1",    instr1, 32'h0);
        check("rst_pc",    instr0_pc, 32'h0);

        n_rst = 1'b0;
        #1;
        check("first_req",  32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'h0);
        tick();
        check("addr_e1", mem_addr, 32'h4);
        tick();
        check("zero_cnt",  32'(count), 32'd1);
        check("zero_v0",   32'(instr0_valid), 32'd1);
        check("zero_i0",   instr0, 32'h0);
        check("zero_pc",   instr0_pc, 32'h0);
        check("zero_v1",   32'(instr1_valid), 32'd0);
        check("zero_req",  32'(mem_req), 32'd1);
        repeat (6) tick();
        check("cred_cnt", 32'(count), 32'd7);
        check("cred_req", 32'(mem_req), 32'd0);
        tick();
        check("full_cnt",  32'(count), 32'd8);
        check("full_req",  32'(mem_req), 32'd0);
        check("full_addr", mem_addr, 32'h20);
        check("full_i1",   instr1, 32'h0004_0004);
        check("full_v1",   32'(instr1_valid), 32'd1);

        pop_cnt = 2'd2; inj = 1'b1; inj_data = 32'hDEAD_BEEF;
        tick();
        pop_cnt = 2'd0; inj = 1'b0;
        check("pp_cnt", 32'(count), 32'd7);
        check("pp_pc",  instr0_pc, 32'h8);
        check("pp_i0",  instr0, 32'h0008_0008);

        auto_rsp = 1'b0; mem_gnt = 1'b0;
        flush = 1'b1; flush_pc = 32'h40;
        tick();
        flush = 1'b0; mem_gnt = 1'b1;
        check("fl_cnt",   32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_pc",    instr0_pc, 32'h40);
        check("fl_addr",  mem_addr, 32'h40);
        check("fl_req",   32'(mem_req), 32'd1);
        tick();
        tick();
        check("out2_req",  32'(mem_req), 32'd0);
        check("out2_addr", mem_addr, 32'h48);
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        check("dr_req",  32'(mem_req), 32'd0);
        check("dr_addr", mem_addr, 32'h100);
        check("dr_pc",   instr0_pc, 32'h100);
        check("dr_cnt",  32'(count), 32'd0);
        inj = 1'b1; inj_data = 32'hCAFE_F00D;
        tick();
        check("dr1_cnt", 32'(count), 32'd0);
        check("dr1_req", 32'(mem_req), 32'd0);
        tick();
        inj = 1'b0;
        #1;
        check("dr2_req",  32'(mem_req), 32'd1);
        check("dr2_addr", mem_addr, 32'h100);
        check("dr2_cnt",  32'(count), 32'd0);
        check("dr2_v0",   32'(instr0_valid), 32'd0);
        check("dr2_i0",   instr0, 32'h0);

        auto_rsp = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        check("one_cnt", 32'(count), 32'd1);
        check("one_i0",  instr0, 32'h0100_0100);
        check("one_pc",  instr0_pc, 32'h100);
        check("one_v1",  32'(instr1_valid), 32'd0);
        pop_cnt = 2'd2;
        tick();
        check("uf_cnt",   32'(count), 32'd0);
        check("uf_empty", 32'(empty), 32'd1);
        check("uf_pc",    instr0_pc, 32'h104);
        check("uf_v0",    32'(instr0_valid), 32'd0);
        tick();
        pop_cnt = 2'd0;
        check("uf2_cnt", 32'(count), 32'd0);
        check("uf2_pc",  instr0_pc, 32'h104);

        en = 1'b0; mem_gnt = 1'b1;
        #1;
        check("en_req", 32'(mem_req), 32'd0);
        tick();
        check("en_addr", mem_addr, 32'h104);
        check("en_cnt",  32'(count), 32'd0);

        en = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("mid_addr", mem_addr, 32'h108);
        n_rst = 1'b1;
        #1;
        check("mid_req",  32'(mem_req), 32'd0);
        check("mid_addr", mem_addr, 32'h0);
        check("mid_pc",   instr0_pc, 32'h0);
        check("mid_cnt",  32'(count), 32'd0);
        tick();
        n_rst = 1'b0;
        #1;

        inj = 1'b1; inj_data = 32'h0013_0313; pop_cnt = 2'd1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("byp_i0", instr0, 32'h0013_0313);
        check("byp_v0", 32'(instr0_valid), 32'd1);
        tick();
        inj = 1'b0; pop_cnt = 2'd0;
        check("byp_cnt", 32'(count), 32'd0);
        check("byp_pc",  instr0_pc, 32'h4);
`else
        check("nb_v0", 32'(instr0_valid), 32'd0);
        check("nb_i0", instr0, 32'h0);
        tick();
        inj = 1'b0; pop_cnt = 2'd0;
        check("nb_cnt", 32'(count), 32'd1);
        check("nb_i0b", instr0, 32'h0013_0313);
        check("nb_pc",  instr0_pc, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
